// File: rtl/alu_reg_file.sv
// alu_reg_file: operand register file feeding the 8-bit ALU.
// Two combinational read ports (ALU A/B), one synchronous write port for the
// ALU result, a registered {V,C,Z} status flag set and a wrapping count of
// committed writes.
// Optional feature macro: ALU_REG_FILE_BYPASS_EN -- when defined, a read of
// the register being written in the same cycle returns wr_data, and flags
// shows the incoming ALU flags while flag_we is high.
module alu_reg_file #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              overflow_in,
  output logic [2:0]        flags,
  output logic [7:0]        wr_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [2:0]        flags_q, flags_d;
  logic [7:0]        wr_cnt_q, wr_cnt_d;
  logic              wr_commit;

  // Register 0 is hardwired to zero when R0_ZERO is set.
  function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
    return (R0_ZERO != 0) && (addr == '0);
  endfunction

  // Read-port value for one address, including the optional same-cycle bypass.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_q[addr];
`ifdef ALU_REG_FILE_BYPASS_EN
    if (wr_en && rst_n && (addr == wr_addr)) val = wr_data;
`endif
    if (is_r0(addr)) val = '0;
    return val;
  endfunction

  // A write commits only when enabled and not aimed at a hardwired-zero r0.
  assign wr_commit = wr_en && !is_r0(wr_addr);

  // Next-state for the register array, write counter and status flags.
  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    flags_d  = flags_q;
    if (wr_commit) begin
      regs_d[wr_addr] = wr_data;
      wr_cnt_d        = wr_cnt_q + 8'd1;
    end
    if (flag_we) begin
      flags_d = {overflow_in, carry_in, zero_in};
    end
  end

  // State registers; reset clears everything and overrides any write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_cnt_q <= '0;
      flags_q  <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
      flags_q  <= flags_d;
    end
  end

  // Combinational read ports and flag output.
  always_comb begin
    rd_a   = read_port(ra_addr);
    rd_b   = read_port(rb_addr);
    wr_cnt = wr_cnt_q;
`ifdef ALU_REG_FILE_BYPASS_EN
    flags  = flag_we ? {overflow_in, carry_in, zero_in} : flags_q;
`else
    flags  = flags_q;
`endif
  end

endmodule

// File: tb/tb_alu_reg_file.sv
// tb_alu_reg_file: directed bench for alu_reg_file with a behavioural model
// of the register file checked on every falling edge, plus literal spot checks.
module tb_alu_reg_file;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] ra_addr, rb_addr, wr_addr;
  logic [DATA_W-1:0] rd_a, rd_b, wr_data;
  logic              wr_en, flag_we, zero_in, carry_in, overflow_in;
  logic [2:0]        flags;
  logic [7:0]        wr_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  logic [7:0] m_regs [8];
  logic [2:0] m_flags;
  int         m_cnt;

  always #20 clk = ~clk;

  alu_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .rd_a(rd_a), .rd_b(rd_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .zero_in(zero_in),
    .carry_in(carry_in), .overflow_in(overflow_in), .flags(flags),
    .wr_cnt(wr_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What a read port must show, from the architectural rules.
  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
`ifdef ALU_REG_FILE_BYPASS_EN
    if (wr_en && rst_n && a == wr_addr) return wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic [2:0] exp_flags();
`ifdef ALU_REG_FILE_BYPASS_EN
    if (flag_we) return {overflow_in, carry_in, zero_in};
`endif
    return m_flags;
  endfunction

  // Model update at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_flags = 3'b000;
      m_cnt   = 0;
    end else begin
      if (wr_en && wr_addr != 3'd0) begin
        m_regs[wr_addr] = wr_data;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (flag_we) m_flags = {overflow_in, carry_in, zero_in};
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_a", rd_a, exp_rd(ra_addr));
      chk("rd_b", rd_b, exp_rd(rb_addr));
      chk("flags", flags, exp_flags());
      chk("wr_cnt", wr_cnt, m_cnt[7:0]);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0; wr_addr = $urandom_range(0, 7); wr_data = $urandom_range(0, 255);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hAA;
    ra_addr = 3'd3; rb_addr = 3'd3;
    flag_we = 1'b1; zero_in = 1'b1; carry_in = 1'b1; overflow_in = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    tick();
    tick();
    // Reset state with reset released and writes idle.
    rst_n = 1'b1; wr_en = 1'b0; flag_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra_addr = i[2:0]; rb_addr = 3'(7 - i);
      #1;
      chk("reset_rd_a", rd_a, 8'h00);
      chk("reset_rd_b", rd_b, 8'h00);
    end
    chk("reset_flags", flags, 3'b000);
    chk("reset_cnt", wr_cnt, 8'd0);

    // Basic write / read.
    wr(3'd2, 8'h5C);
    wr(3'd7, 8'hF0);
    ra_addr = 3'd2; rb_addr = 3'd7;
    #1;
    chk("wr_rd_a", rd_a, 8'h5C);
    chk("wr_rd_b", rd_b, 8'hF0);
    chk("wr_cnt2", wr_cnt, 8'd2);
    rb_addr = 3'd2;
    #1 chk("same_port_b", rd_b, 8'h5C);

    // r0 ignores writes and counter does not move.
    wr(3'd0, 8'hFF);
    ra_addr = 3'd0;
    #1;
    chk("r0_read", rd_a, 8'h00);
    chk("r0_cnt", wr_cnt, 8'd2);

    // Same-cycle write/read of r4.
    wr(3'd4, 8'h11);
    ra_addr = 3'd4; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h22;
    #1;
`ifdef ALU_REG_FILE_BYPASS_EN
    chk("hazard_before", rd_a, 8'h22);
`else
    chk("hazard_before", rd_a, 8'h11);
`endif
    tick();
    wr_en = 1'b0;
    #1 chk("hazard_after", rd_a, 8'h22);

    // Flags capture and hold.
    flag_we = 1'b1; zero_in = 1'b0; carry_in = 1'b1; overflow_in = 1'b1;
    tick();
    flag_we = 1'b0; zero_in = 1'b1; carry_in = 1'b0; overflow_in = 1'b0;
    #1 chk("flags_cap", flags, 3'b110);
    tick();
    chk("flags_hold", flags, 3'b110);

    // Simultaneous write and flag capture.
    flag_we = 1'b1; zero_in = 1'b1; carry_in = 1'b0; overflow_in = 1'b0;
    wr(3'd5, 8'h00);
    flag_we = 1'b0;
    ra_addr = 3'd5;
    #1;
    chk("alu_flags", flags, 3'b001);
    chk("alu_cnt", wr_cnt, 8'd5);

    // Idle cycles with random don't-care write address/data.
    for (int i = 0; i < 6; i++) begin
      wr_addr = $urandom_range(0, 7); wr_data = $urandom_range(0, 255);
      ra_addr = $urandom_range(0, 7); rb_addr = $urandom_range(0, 7);
      tick();
    end

    // Counter wrap: reset, then 256 writes to r1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ra_addr = 3'd1;
    for (int i = 0; i < 256; i++) wr(3'd1, 8'(i + 3));
    chk("wrap_cnt", wr_cnt, 8'd0);
    chk("wrap_r1", rd_a, 8'h02);
    wr(3'd1, 8'h77);
    wr(3'd6, 8'h88);
    chk("post_wrap_cnt", wr_cnt, 8'd2);

    // Reset mid-run with a write presented: write discarded.
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h99;
#1;
`ifndef ALU_REG_FILE_BYPASS_EN
    chk("rst_no_bypass", rd_a, 8'h77);
`else
    chk("rst_no_bypass", rd_a, 8'h77);
`endif
    tick();
    rst_n = 1'b1; wr_en = 1'b0;
    #1;
    chk("midrst_cnt", wr_cnt, 8'd0);
    chk("midrst_r1", rd_a, 8'h00);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_reg_file.md
Name: alu_reg_file

Overview:
- Operand register file directly upstream of the 8-bit ALU in the single-cycle CPU.
- Supplies ALU inputs A and B from two combinational read ports.
- Accepts the ALU result on one synchronous write port.
- Holds the architectural status flags (Z, C, V) captured from the ALU flag outputs, for use by branch logic.

Parameters:
- DATA_W, 8, register and ALU operand width in bits.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W = 8.
- R0_ZERO, 1, when 1, register 0 reads constant 0 and ignores writes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- ra_addr  input  ADDR_W  read port A address (drives ALU A).
- rb_addr  input  ADDR_W  read port B address (drives ALU B).
- rd_a  output  DATA_W  read port A data, combinational.
- rd_b  output  DATA_W  read port B data, combinational.
- wr_en  input  1  write enable for the data register array.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data (ALU result or load value).
- flag_we  input  1  capture enable for the status flags.
- zero_in  input  1  ALU zero flag.
- carry_in  input  1  ALU carry/borrow flag.
- overflow_in  input  1  ALU signed overflow flag.
- flags  output  3  registered flags {V, C, Z}.
- wr_cnt  output  8  count of committed writes, wrapping.

Behaviour:
- Clocking: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk). No asynchronous paths into state.
- Reset: on a rising clk with rst_n=0:
  - all NUM_REGS registers become 0; flags become 3'b000; wr_cnt becomes 0.
  - wr_en and flag_we are ignored in that cycle; reset wins over every simultaneous event.
  - Reset asserted mid-sequence discards any write presented in that cycle.
- Reads: rd_a = reg[ra_addr], rd_b = reg[rb_addr]; purely combinational, zero latency. Both ports may address the same register.
- Writes:
  - On a rising clk with rst_n=1 and wr_en=1, reg[wr_addr] <= wr_data. The new value is visible on the read ports the cycle after the edge.
  - wr_cnt increments by 1 on each committed write, wrapping 255 -> 0.
- R0_ZERO=1:
  - Reads of address 0 return 0 regardless of stored contents.
  - Writes to address 0 are dropped and do not increment wr_cnt.
- Same-cycle read/write of the same address: reads return the old value; see Optional Feature.
- Flags:
  - On a rising clk with rst_n=1 and flag_we=1: flags <= {overflow_in, carry_in, zero_in}. Otherwise flags hold.
  - flag_we is independent of wr_en; both may be asserted in the same cycle (normal ALU instruction case).
- X-safety: with wr_en=0, wr_addr and wr_data are don't-care and must not alter state.

Optional Feature:
- Macro: ALU_REG_FILE_BYPASS_EN.
- Defined:
  - If wr_en=1, rst_n=1 and a read address equals wr_addr (and is not register 0 when R0_ZERO=1), that read port returns wr_data combinationally in the same cycle.
  - The flags output also bypasses: it shows {overflow_in, carry_in, zero_in} while flag_we=1.
- Undefined: no bypass; reads and flags always show registered state.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with wr_en=1, wr_addr=3, wr_data=8'hAA -> rd_a/rd_b of every address = 0, flags=000, wr_cnt=0.
- Write/read: write 8'h5C to r2, 8'hF0 to r7; set ra=2, rb=7 -> rd_a=8'h5C, rd_b=8'hF0; wr_cnt=2.
- R0: write 8'hFF to r0 -> rd_a with ra=0 is 8'h00, wr_cnt unchanged.
- Same-cycle hazard: r4=8'h11; write 8'h22 to r4 while ra=4:
  - no macro -> rd_a=8'h11 before the edge, 8'h22 after.
  - with ALU_REG_FILE_BYPASS_EN -> rd_a=8'h22 immediately.
- Flags: flag_we=1 with zero_in=0, carry_in=1, overflow_in=1 -> flags=3'b110 next cycle. flag_we=0 with new inputs -> flags hold 3'b110.
- Counter wrap: 256 writes to r1 -> wr_cnt returns to 0. Reset issued mid-run -> wr_cnt=0 and r1=0 on the next cycle.
